// File: rtl/seq_shifter_if.sv
// Request/response bundle for the iterative shift/rotate unit.
// The slave modport is the shifter; the master modport is whoever issues requests.
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [2:0]       op;
    logic [SHW-1:0]   amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, data_in, op, amt, out_ready,
        input  in_ready, out_valid, data_out, carry_out, zero, busy
    );

    modport slave (
        input  in_valid, data_in, op, amt, out_ready,
        output in_ready, out_valid, data_out, carry_out, zero, busy
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock, valid/ready on both sides.
// Reports the last bit shifted or rotated out as carry_out, plus a zero flag on the result.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    seq_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_ASR = 3'b101;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   step_res;

    function automatic logic is_pass(input logic [2:0] o);
        return !(o == OP_LSL || o == OP_LSR || o == OP_ROL || o == OP_ROR || o == OP_ASR);
    endfunction

    // Single-position step; returns {carry, data}.
    function automatic logic [WIDTH:0] step(input logic [2:0] o, input logic [WIDTH-1:0] d);
        logic [WIDTH:0] r;
        case (o)
            OP_LSL:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            OP_LSR:  r = {d[0], 1'b0, d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
            OP_ASR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    assign step_res = step(op_q, data_q);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.data_in;
                    op_d    = bus.op;
                    cnt_d   = bus.amt;
                    carry_d = 1'b0;
                    state_d = (bus.amt == '0 || is_pass(bus.op)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d  = step_res[WIDTH-1:0];
                carry_d = step_res[WIDTH];
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    // in_ready drops combinationally while rst is asserted so nothing is accepted into a reset.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.data_out  = data_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = (data_q == '0);
endmodule

// File: tb/tb_seq_shifter.sv
// Directed plus randomized bench for seq_shifter (WIDTH=16, SHW=4) against an arithmetic model.
module tb_seq_shifter;
    localparam int W = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_shifter_if #(.WIDTH(W), .SHW(S)) sif ();

    seq_shifter #(.WIDTH(W), .SHW(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-amount shifts and rotates with plain operators.
    function automatic void model(input logic [2:0] o, input int a, input logic [W-1:0] d,
                                  output logic [W-1:0] r, output logic c);
        int k;
        k = a % W;
        r = d;
        c = 1'b0;
        if (a != 0) begin
            case (o)
                3'd1: begin r = (a >= W) ? '0 : d << a; c = (a <= W) ? d[W-a] : 1'b0; end
                3'd2: begin r = (a >= W) ? '0 : d >> a; c = (a <= W) ? d[a-1] : 1'b0; end
                3'd3: begin r = (d << k) | (d >> (W - k)); c = r[0]; end
                3'd4: begin r = (d >> k) | (d << (W - k)); c = r[W-1]; end
                3'd5: begin r = W'($signed(d) >>> a); c = (a <= W) ? d[a-1] : d[W-1]; end
                default: begin r = d; c = 1'b0; end
            endcase
        end
    endfunction

    // Issue one request, measure latency, check result, then retire it.
    task automatic do_req(input logic [2:0] o, input logic [S-1:0] a, input logic [W-1:0] d,
                          input string tag);
        logic [W-1:0] er;
        logic         ec;
        int           lat;
        int           exp_lat;
        @(negedge clk);
        sif.in_valid  = 1'b1;
        sif.data_in   = d;
        sif.op        = o;
        sif.amt       = a;
        sif.out_ready = 1'b0;
        check({tag, "_in_ready"}, 32'(sif.in_ready), 32'd1);
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        lat = 1;
        while (!sif.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = (a == 0 || o == 3'd0 || o > 3'd5) ? 1 : int'(a) + 1;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        model(o, int'(a), d, er, ec);
        check({tag, "_data"}, 32'(sif.data_out), 32'(er));
        check({tag, "_carry"}, 32'(sif.carry_out), 32'(ec));
        check({tag, "_zero"}, 32'(sif.zero), 32'(er == '0));
        check({tag, "_busy_done"}, {30'd0, sif.busy, sif.in_ready}, 32'b10);
        @(negedge clk);
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.out_ready = 1'b0;
        check({tag, "_back_idle"}, {29'd0, sif.out_valid, sif.busy, sif.in_ready}, 32'b001);
    endtask

    initial begin
        logic [W-1:0] held_d;
        logic         held_c;
        int           seen;
        rst           = 1'b1;
        sif.in_valid  = 1'b0;
        sif.data_in   = '0;
        sif.op        = '0;
        sif.amt       = '0;
        sif.out_ready = 1'b0;

        // Reset state
        @(posedge clk); #1;
        check("rst_in_ready", 32'(sif.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state", {28'd0, sif.out_valid, sif.busy, sif.carry_out, sif.in_ready}, 32'b0001);
        check("rst_data", 32'(sif.data_out), 32'd0);

        // Specification examples
        do_req(3'b001, 4'd1,  16'h8001, "lsl1");
        check("lsl1_val", 32'(sif.data_out), 32'h0002);
        do_req(3'b100, 4'd4,  16'h1234, "ror4");
        check("ror4_val", 32'(sif.data_out), 32'h4123);
        do_req(3'b011, 4'd4,  16'h1234, "rol4");
        check("rol4_val", {15'd0, sif.carry_out, sif.data_out}, 32'h12341);
        do_req(3'b101, 4'd3,  16'h8010, "asr3");
        check("asr3_val", 32'(sif.data_out), 32'hF002);
        do_req(3'b010, 4'd15, 16'h4000, "lsr15");
        check("lsr15_val", {14'd0, sif.zero, sif.carry_out, sif.data_out}, 32'h30000);
        do_req(3'b000, 4'd7,  16'hA5A5, "pass0");
        do_req(3'b111, 4'd7,  16'hA5A5, "pass7");
        do_req(3'b001, 4'd0,  16'hA5A5, "amt0");
        check("amt0_val", {15'd0, sif.carry_out, sif.data_out}, 32'h0A5A5);
        do_req(3'b101, 4'd15, 16'h8000, "asr15");
        do_req(3'b011, 4'd15, 16'h8001, "rol15");

        // Hold in DONE with out_ready low; in_valid pulses must be ignored
        @(negedge clk);
        sif.in_valid = 1'b1; sif.op = 3'b001; sif.amt = 4'd2; sif.data_in = 16'hC003;
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_enter", 32'(sif.out_valid), 32'd1);
        held_d = sif.data_out;
        held_c = sif.carry_out;
        check("hold_val", {15'd0, held_c, held_d}, 32'h1000C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sif.in_valid = i[0];
            sif.data_in  = 16'hFFFF;
            sif.op       = 3'b000;
            @(posedge clk); #1;
            check("hold_stable", {13'd0, sif.out_valid, sif.in_ready, sif.carry_out, sif.data_out},
                  {13'd0, 1'b1, 1'b0, held_c, held_d});
        end
        @(negedge clk);
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.out_ready = 1'b0;
        check("hold_release", {30'd0, sif.out_valid, sif.in_ready}, 32'b01);

        // Reset mid-SHIFT discards the operation
        @(negedge clk);
        sif.in_valid = 1'b1; sif.op = 3'b001; sif.amt = 4'd10; sif.data_in = 16'h00FF;
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(sif.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_state", {29'd0, sif.out_valid, sif.busy, sif.in_ready}, 32'b001);
        check("midrst_data", 32'(sif.data_out), 32'd0);
        seen = 0;
        sif.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (sif.out_valid) seen++;
        end
        sif.out_ready = 1'b0;
        check("midrst_no_result", 32'(seen), 32'd0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            do_req(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
